fetch_stage: RTL and testbench

//   Instruction-fetch stage of the 8-bit processor: owns the program counter, drives the

---
 rtl/fetch_stage.sv | 52 +++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-memory address and IF/ID register with stall, branch redirect and HALT
module fetch_stage #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_WORD    = 16'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic [15:0] id_instr,
  output logic [7:0]  id_pc,
  output logic        id_valid,
  output logic        halted
);
  typedef enum logic [1:0] {RUN, HALTED} state_t;
  state_t     state;
  logic [7:0] pc;
  assign imem_addr = pc;
  always_ff @(posedge clk)
    if (reset) begin
      pc       <= RESET_PC;
      state    <= RUN;
      id_instr <= NOP_WORD;
      id_pc    <= 8'h00;
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (branch_taken) begin
      pc       <= branch_target;
      state    <= RUN;
      id_instr <= NOP_WORD;
      id_pc    <= 8'h00;
      id_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (state == HALTED) begin
      id_instr <= NOP_WORD;
      id_pc    <= 8'h00;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_instr <= imem_data;
      id_pc    <= pc;
      id_valid <= 1'b1;
      if (imem_data[15:12] == HALT_OPCODE) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else
        pc <= pc + 8'd1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench comparing fetch_stage against a cycle-level behavioural model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic        halted;
  logic        reset_fe = 1'b1;
  logic [7:0]  imem_addr_fe;
  logic [15:0] id_instr_fe;
  logic [7:0]  id_pc_fe;
  logic        id_valid_fe;
  logic        halted_fe;
  logic [15:0] mem [256];
  int          n_checks = 0;
  int          n_fails = 0;
  typedef struct {
    logic [7:0]  pc;
    logic        v;
    logic [7:0]  idpc;
    logic [15:0] ins;
    logic        h;
  } exp_t;
  exp_t        q[$];
  logic [7:0]  m_pc = 8'h00;
  logic        m_h = 1'b0;
  logic        m_v = 1'b0;
  logic [7:0]  m_idpc = 8'h00;
  logic [15:0] m_ins = 16'h0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid), .halted(halted)
  );
  fetch_stage #(.RESET_PC(8'hFE)) u_fe (
    .clk(clk), .reset(reset_fe), .imem_addr(imem_addr_fe), .imem_data({8'h10, imem_addr_fe}),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(8'h00),
    .id_instr(id_instr_fe), .id_pc(id_pc_fe), .id_valid(id_valid_fe), .halted(halted_fe)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] t);
    logic [15:0] w;
    reset = r;
    stall = s;
    branch_taken = b;
    branch_target = t;
    if (r) begin
      m_pc = 8'h00; m_h = 1'b0; m_v = 1'b0; m_idpc = 8'h00; m_ins = 16'h0;
    end else if (b) begin
      m_pc = t; m_h = 1'b0; m_v = 1'b0; m_idpc = 8'h00; m_ins = 16'h0;
    end else if (m_h) begin
      m_v = 1'b0; m_ins = 16'h0;
    end else if (!s) begin
      w = mem[m_pc];
      m_v = 1'b1; m_idpc = m_pc; m_ins = w;
      if (w[15:12] == 4'hF) m_h = 1'b1;
      else m_pc = 8'((int'(m_pc) + 1) % 256);
    end
    q.push_back('{pc: m_pc, v: m_v, idpc: m_idpc, ins: m_ins, h: m_h});
    @(negedge clk);
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("imem_addr", 32'(imem_addr), 32'(e.pc));
      chk("id_valid", 32'(id_valid), 32'(e.v));
      chk("id_instr", 32'(id_instr), 32'(e.ins));
      chk("halted", 32'(halted), 32'(e.h));
      if (e.v) chk("id_pc", 32'(id_pc), 32'(e.idpc));
    end
  end
  initial begin
    logic [7:0] fe_seq [4];
    fe_seq[0] = 8'hFE; fe_seq[1] = 8'hFF; fe_seq[2] = 8'h00; fe_seq[3] = 8'h01;
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);
    @(negedge clk);
    @(negedge clk);
    reset_fe = 1'b0;
    chk("fe_reset_addr", 32'(imem_addr_fe), 32'hFE);
    chk("fe_reset_valid", 32'(id_valid_fe), 32'h0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("fe_addr", 32'(imem_addr_fe), 32'(fe_seq[i]));
      chk("fe_id_pc", 32'(id_pc_fe), 32'(fe_seq[i-1]));
      chk("fe_valid", 32'(id_valid_fe), 32'h1);
    end
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 1, 1, 8'h40);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    mem[3] = 16'hF000;
    for (int i = 0; i < 14; i++) step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h10);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(7) == 0) mem[i][15:12] = 4'hF;
      else if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'hE;
    end
    for (int i = 0; i < 800; i++)
      step($urandom_range(40) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, 8'($urandom));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
